// File: rtl/prf_wb_arbiter_pkg.sv
// Shared constants and bundle types for the PRF write-back arbiter slice.
// Replaces the sys_defs.svh macros with package-scoped equivalents.
package prf_wb_arbiter_pkg;

    localparam int unsigned NUM_WB_REQ  = 4;
    localparam int unsigned PHYS_REG_SZ = 64;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned PRF_TAG_W   = $clog2(PHYS_REG_SZ);

    typedef struct packed {
        logic                 valid;
        logic [PRF_TAG_W-1:0] tag;
        logic [XLEN-1:0]      data;
    } WB_REQ_PACKET;

    typedef struct packed {
        logic                 write_en;
        logic [PRF_TAG_W-1:0] write_tag;
        logic [XLEN-1:0]      write_data;
    } IC_PRF_PACKET;

    // Modulo-n increment without a divider for non-power-of-two n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prf_wb_arbiter_if.sv
// Request/write-back bundle between the execute-stage requesters and the arbiter.
// The master side drives requests and observes the CDB; the slave side is the arbiter.
interface prf_wb_arbiter_if
    import prf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_WB_REQ,
    parameter int unsigned TAG_W   = PRF_TAG_W,
    parameter int unsigned DATA_W  = XLEN,
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           wb_en;
    logic [TAG_W-1:0]               wb_tag;
    logic [DATA_W-1:0]              wb_data;
    logic [SRC_W-1:0]               wb_src;
    logic                           busy;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, wb_en, wb_tag, wb_data, wb_src, busy
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, wb_en, wb_tag, wb_data, wb_src, busy
    );

endinterface

// File: rtl/prf_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Emits a one-hot grant, its index, and whether anything was granted.
module rr_picker #(
    parameter int unsigned N       = 4,
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = IDX_W'((32'(ptr) + off) % N);
            if (!any_gnt && req[idx]) begin
                any_gnt   = 1'b1;
                gnt_idx   = idx;
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Arbitrates NUM_REQ completing units onto the single registered PRF write port / CDB.
// Each requester owns a 1-entry holding buffer; a round-robin pick drains one per cycle.
module prf_wb_arbiter
    import prf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_WB_REQ,
    parameter int unsigned TAG_W   = PRF_TAG_W,
    parameter int unsigned DATA_W  = XLEN,
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    prf_wb_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]             buf_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0] buf_data;
    logic [SRC_W-1:0]               rr_ptr;

    logic                           wb_en_q;
    logic [TAG_W-1:0]               wb_tag_q;
    logic [DATA_W-1:0]              wb_data_q;
    logic [SRC_W-1:0]               wb_src_q;

    logic [NUM_REQ-1:0]             gnt;
    logic [SRC_W-1:0]               gnt_idx;
    logic                           any_gnt;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             accept;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req     (buf_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // A buffer can be refilled on the same edge it drains, so a winning
    // requester sustains one result per cycle.
    always_comb begin
        req_ready = squash ? '1 : (~buf_valid | gnt);
        accept    = bus.req_valid & req_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            wb_en_q   <= 1'b0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
            wb_src_q  <= '0;
        end else if (squash) begin
            buf_valid <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                // Tag 0 is the hard-wired zero register: accept and drop.
                if (accept[i] && (bus.req_tag[i] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= bus.req_tag[i];
                    buf_data[i]  <= bus.req_data[i];
                end else if (gnt[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (any_gnt) begin
                wb_en_q   <= 1'b1;
                wb_tag_q  <= buf_tag[gnt_idx];
                wb_data_q <= buf_data[gnt_idx];
                wb_src_q  <= gnt_idx;
                rr_ptr    <= SRC_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
            end else begin
                wb_en_q   <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_src    = wb_src_q;
    assign bus.busy      = |buf_valid;

endmodule
